// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide unit that owns the architectural HI/LO pair.
// It sits in EX next to the single-cycle ALU and shares its operand buses.
//
//   MULT / MULTU : one busy cycle. {hi,lo} = 64-bit product.
//   DIV  / DIVU  : 32 busy cycles of radix-2 restoring division.
//                  lo = quotient, hi = remainder.
//   MTHI / MTLO  : hi or lo = a at the accept edge. Never busy, no done.
//
// Ports
//   clk       in   1   clock, all state on the rising edge
//   reset     in   1   synchronous, active-high; beats every other input
//   in_valid  in   1   EX presents a muldiv instruction this cycle
//   op        in   6   one-hot: [0]MULT [1]MULTU [2]DIV [3]DIVU [4]MTHI [5]MTLO
//   a         in  32   rs operand (dividend / multiplicand / MT source)
//   b         in  32   rt operand (divisor / multiplier)
//   cancel    in   1   pipeline flush: kills an accept and any in-flight op
//   in_ready  out  1   unit can accept an op (== ~busy)
//   busy      out  1   multi-cycle op in flight
//   done      out  1   one-cycle pulse: hi/lo were just written by MULT*/DIV*
//   hi        out 32   HI register
//   lo        out 32   LO register
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        in_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    state_t state_reg;
    state_t state_next;

    // Architectural registers and the done pulse
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // Multiplier operands, already extended to 33 bits at accept time
    logic [32:0] mul_a_reg;
    logic [32:0] mul_b_reg;

    // Divider working state
    logic [31:0] quot_reg;    // holds remaining dividend bits, fills with quotient
    logic [31:0] rem_reg;     // partial remainder, always < divisor (or 0-divisor case)
    logic [31:0] dvs_reg;     // divisor magnitude
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [5:0]  count_reg;

    // -------------------------------------------------------------------------
    // Accept decode
    // -------------------------------------------------------------------------
    logic accept;
    logic start_mul;
    logic start_div;
    logic write_mthi;
    logic write_mtlo;

    assign accept     = in_valid & in_ready & ~cancel & (|op);
    assign start_mul  = accept & (op[0] | op[1]);
    assign start_div  = accept & (op[2] | op[3]);
    assign write_mthi = accept & op[4];
    assign write_mtlo = accept & op[5];

    // -------------------------------------------------------------------------
    // Divide operand conditioning: signed DIV works on magnitudes and fixes
    // the signs of the results at the end. Index 0 is the dividend, 1 the
    // divisor. 0x80000000 negates to itself, which is the correct unsigned
    // magnitude, so no special case is needed.
    // -------------------------------------------------------------------------
    logic [31:0] div_in  [2];
    logic [31:0] div_mag [2];
    logic        div_neg [2];

    assign div_in[0] = a;
    assign div_in[1] = b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_div_mag
            assign div_neg[gi] = op[2] & div_in[gi][31];
            assign div_mag[gi] = div_neg[gi] ? (~div_in[gi] + 32'd1) : div_in[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Multiplier: sign/zero extension to 33 bits happened at accept, so one
    // wrap-around 64-bit multiply of the further-extended operands yields the
    // correct low 64 bits for both MULT and MULTU.
    // -------------------------------------------------------------------------
    logic [63:0] mul_a_wide;
    logic [63:0] mul_b_wide;
    logic [63:0] product;

    assign mul_a_wide = {{31{mul_a_reg[32]}}, mul_a_reg};
    assign mul_b_wide = {{31{mul_b_reg[32]}}, mul_b_reg};
    assign product    = mul_a_wide * mul_b_wide;

    // -------------------------------------------------------------------------
    // Restoring divide step: shift the next dividend bit into the remainder,
    // subtract when it fits. With a zero divisor every step "fits", giving
    // q = all ones and r = dividend without any special handling.
    // -------------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic [31:0] q_final;
    logic [31:0] r_final;
    logic        last_step;

    assign rem_shift = {rem_reg, quot_reg[31]};
    assign rem_ge    = rem_shift >= {1'b0, dvs_reg};
    // When rem_ge holds the true difference fits in 32 bits, so modular
    // subtraction on the low bits is exact.
    assign rem_step  = rem_ge ? (rem_shift[31:0] - dvs_reg) : rem_shift[31:0];
    assign quot_step = {quot_reg[30:0], rem_ge};
    assign q_final   = neg_q_reg ? (~quot_step + 32'd1) : quot_step;
    assign r_final   = neg_r_reg ? (~rem_step + 32'd1) : rem_step;
    assign last_step = (count_reg == LAST_STEP);

    // Result write strobes; a flush in the final cycle discards the result.
    logic mul_write;
    logic div_write;

    assign mul_write = (state_reg == MUL) & ~cancel;
    assign div_write = (state_reg == DIV) & last_step & ~cancel;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_mul) begin
                    state_next = MUL;
                end else if (start_div) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                state_next = IDLE;
            end
            DIV: begin
                if (cancel || last_step) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and architectural registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            done_reg  <= 1'b0;
            mul_a_reg <= 33'd0;
            mul_b_reg <= 33'd0;
            quot_reg  <= 32'd0;
            rem_reg   <= 32'd0;
            dvs_reg   <= 32'd0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            count_reg <= 6'd0;
        end else begin
            done_reg <= mul_write | div_write;

            if (start_mul) begin
                mul_a_reg <= {op[0] & a[31], a};
                mul_b_reg <= {op[0] & b[31], b};
            end

            if (start_div) begin
                quot_reg  <= div_mag[0];
                rem_reg   <= 32'd0;
                dvs_reg   <= div_mag[1];
                neg_q_reg <= op[2] & (a[31] ^ b[31]);
                neg_r_reg <= op[2] & a[31];
                count_reg <= 6'd0;
            end else if (state_reg == DIV) begin
                quot_reg  <= quot_step;
                rem_reg   <= rem_step;
                count_reg <= count_reg + 6'd1;
            end

            // Result writes only happen while busy and MT writes only while
            // idle, so these branches never compete in practice.
            if (mul_write) begin
                hi_reg <= product[63:32];
                lo_reg <= product[31:0];
            end else if (div_write) begin
                hi_reg <= r_final;
                lo_reg <= q_final;
            end else begin
                if (write_mthi) begin
                    hi_reg <= a;
                end
                if (write_mtlo) begin
                    lo_reg <= a;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy     = (state_reg != IDLE);
    assign in_ready = ~busy;
    assign done     = done_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Self-checking bench for muldiv_unit. A vector table of MULT*/DIV* ops
// (fixed corner cases plus random ones whose expectations come from native
// arithmetic) is applied in a loop. Expected results are pushed to a
// scoreboard queue at issue time and popped by a monitor on every done
// pulse. Hand-written sequences cover MTHI/MTLO, cancel, mid-op reset and
// back-to-back issue in the done cycle.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam logic [5:0] OP_MULT  = 6'b000001;
    localparam logic [5:0] OP_MULTU = 6'b000010;
    localparam logic [5:0] OP_DIV   = 6'b000100;
    localparam logic [5:0] OP_DIVU  = 6'b001000;
    localparam logic [5:0] OP_MTHI  = 6'b010000;
    localparam logic [5:0] OP_MTLO  = 6'b100000;
    localparam int NVEC = 14;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          issue;
        int          lat;
        int          tag;
    } sb_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [5:0]  op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        cancel;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   dones = 0;
    sb_t  sb_q[$];
    sb_t  mon_e;
    vec_t vecs[NVEC];

    muldiv_unit #(.DIV_STEPS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .op       (op),
        .a        (a_in),
        .b        (b_in),
        .cancel   (cancel),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: native arithmetic plus the architected divide-by-zero rule.
    function automatic void model(input logic [5:0] o, input logic [31:0] va, input logic [31:0] vb,
                                  output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        eh = 32'd0;
        el = 32'd0;
        lat = 33;
        if (o == OP_MULT) begin
            p = 64'(sa * sb);
            eh = p[63:32];
            el = p[31:0];
            lat = 2;
        end else if (o == OP_MULTU) begin
            p = {32'd0, va} * {32'd0, vb};
            eh = p[63:32];
            el = p[31:0];
            lat = 2;
        end else if (o == OP_DIV) begin
            if (vb == 32'd0) begin
                eh = va;
                el = va[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
            end else begin
                q = sa / sb;
                r = sa % sb;
                el = q[31:0];
                eh = r[31:0];
            end
        end else begin
            if (vb == 32'd0) begin
                eh = va;
                el = 32'hFFFF_FFFF;
            end else begin
                el = va / vb;
                eh = va % vb;
            end
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (!reset && done) begin
            dones++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want done=0 (nothing pending) cycle %0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                $display("op %0d done: hi=0x%08h lo=0x%08h latency=%0d", mon_e.tag, hi, lo, cyc - mon_e.issue);
                check($sformatf("hi[%0d]", mon_e.tag), hi, mon_e.exp_hi);
                check($sformatf("lo[%0d]", mon_e.tag), lo, mon_e.exp_lo);
                check($sformatf("latency[%0d]", mon_e.tag), 32'(cyc - mon_e.issue), 32'(mon_e.lat));
            end
        end
    end

    // Issue one op starting at a negedge; returns at the negedge of cycle T+1.
    task automatic send(input logic [5:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input bit push, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input int tag);
        int  w;
        sb_t e;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_wait[%0d]: got in_ready=0 want 1 after %0d cycles", tag, w);
        end
        in_valid = 1'b1;
        op       = o;
        a_in     = va;
        b_in     = vb;
        if (push) begin
            e.exp_hi = eh;
            e.exp_lo = el;
            e.issue  = cyc;
            e.lat    = lat;
            e.tag    = tag;
            sb_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        op       = 6'd0;
    endtask

    task automatic wait_drained(input string name);
        int k;
        k = 0;
        while ((busy || sb_q.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        int   nb;
        int   k;
        int   d0;
        logic [5:0] rops [4];

        reset    = 1'b1;
        in_valid = 1'b0;
        op       = 6'd0;
        a_in     = 32'd0;
        b_in     = 32'd0;
        cancel   = 1'b0;

        // Fixed corner vectors
        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
        vecs[4] = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 33};
        vecs[5] = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'h0000_0001, 33};
        vecs[6] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
        // Random vectors, expectations from the model
        rops[0] = OP_MULT;
        rops[1] = OP_MULTU;
        rops[2] = OP_DIV;
        rops[3] = OP_DIVU;
        for (int i = 8; i < NVEC; i++) begin
            vecs[i].op = rops[i % 4];
            vecs[i].a  = $urandom;
            vecs[i].b  = (i >= 12) ? $urandom_range(1, 1000) : $urandom;
            model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven MULT*/DIV* vectors
        for (int i = 0; i < NVEC; i++) begin
            $display("issue %0d: op=%06b a=0x%08h b=0x%08h", i, vecs[i].op, vecs[i].a, vecs[i].b);
            send(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat, i);
            nb = 0;
            k  = 0;
            while (busy && k < 100) begin
                nb++;
                @(negedge clk);
                k++;
            end
            check($sformatf("busy_cycles[%0d]", i), 32'(nb), 32'(vecs[i].lat - 1));
            @(negedge clk);
            check($sformatf("drained[%0d]", i), 32'(sb_q.size()), 32'd0);
            check($sformatf("ready_after[%0d]", i), 32'(in_ready), 32'd1);
        end

        // MTHI: immediate write, never busy, no done
        send(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, 32'd0, 32'd0, 0, 100);
        $display("mthi: hi=0x%08h busy=%0d done=%0d", hi, busy, done);
        check("mthi_hi", hi, 32'h1234_5678);
        check("mthi_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("mthi_busy2", 32'(busy), 32'd0);
        check("mthi_done2", 32'(done), 32'd0);

        // Preload, then cancel a DIVU at iteration 10
        send(OP_MTHI, 32'hAAAA_0000, 32'd0, 1'b0, 32'd0, 32'd0, 0, 101);
        send(OP_MTLO, 32'h0000_BBBB, 32'd0, 1'b0, 32'd0, 32'd0, 0, 102);
        check("pre_hi", hi, 32'hAAAA_0000);
        check("pre_lo", lo, 32'h0000_BBBB);
        send(OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 0, 103);
        repeat (10) @(negedge clk);
        check("cancel_busy_before", 32'(busy), 32'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        $display("cancel divu: busy=%0d in_ready=%0d hi=0x%08h lo=0x%08h", busy, in_ready, hi, lo);
        check("cancel_busy", 32'(busy), 32'd0);
        check("cancel_ready", 32'(in_ready), 32'd1);
        check("cancel_done", 32'(done), 32'd0);
        check("cancel_hi", hi, 32'hAAAA_0000);
        check("cancel_lo", lo, 32'h0000_BBBB);
        repeat (40) @(negedge clk);
        check("cancel_hi_late", hi, 32'hAAAA_0000);
        check("cancel_lo_late", lo, 32'h0000_BBBB);

        // MTLO killed by cancel in the same cycle
        cancel = 1'b1;
        send(OP_MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 32'd0, 32'd0, 0, 104);
        cancel = 1'b0;
        $display("cancelled mtlo: lo=0x%08h", lo);
        check("mtlo_cancel_lo", lo, 32'h0000_BBBB);
        @(negedge clk);
        check("mtlo_cancel_lo2", lo, 32'h0000_BBBB);

        // Reset at DIV iteration 5
        send(OP_DIV, 32'h0000_0100, 32'd5, 1'b0, 32'd0, 32'd0, 0, 105);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        $display("reset mid-div: busy=%0d hi=0x%08h lo=0x%08h done=%0d", busy, hi, lo, done);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // Back-to-back: DIV accepted in the done cycle of a MULT
        d0 = dones;
        send(OP_MULT, 32'd7, 32'hFFFF_FFFA, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 2, 200);
        @(negedge clk);
        check("b2b_done_cycle", 32'(done), 32'd1);
        check("b2b_ready", 32'(in_ready), 32'd1);
        send(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33, 201);
        check("b2b_div_busy", 32'(busy), 32'd1);
        wait_drained("b2b");
        repeat (3) @(negedge clk);
        check("b2b_done_count", 32'(dones - d0), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
